// File: rtl/mux8_frame_serializer.sv
// Serializes a captured WIDTH-bit word LSB first, stepping the mux select once per clock.
// Optional even-parity trailer bit is compiled in with SERIALIZER_PARITY_EN.
module mux8_frame_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   SEL_W    = $clog2(WIDTH),
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             ser_bit_o,
    output logic             ser_valid_o,
    output logic             frame_last_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
`ifdef SERIALIZER_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ser_bit_q, ser_bit_d;
    logic               ser_valid_q, ser_valid_d;
    logic               frame_last_q, frame_last_d;
    logic [SEL_W-1:0]   sel_inc;
    logic               frame_end;
    logic               ready;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        sel_d        = sel_q;
        ser_bit_d    = ser_bit_q;
        ser_valid_d  = ser_valid_q;
        frame_last_d = frame_last_q;
        frame_end    = 1'b0;
        ready        = 1'b0;
        sel_inc      = sel_q + SEL_W'(1);

        case (state_q)
            ST_IDLE: frame_end = 1'b1;
            ST_SHIFT: begin
                if (sel_q != LAST_SEL) begin
                    sel_d     = sel_inc;
                    ser_bit_d = word_q[sel_inc];
`ifdef SERIALIZER_PARITY_EN
                    frame_last_d = 1'b0;
`else
                    frame_last_d = (sel_inc == LAST_SEL);
`endif
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    // sel holds at the last index while the parity bit goes out
                    state_d      = ST_PARITY;
                    ser_bit_d    = ^word_q;
                    frame_last_d = 1'b1;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: frame_end = 1'b1;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Idle and the final frame cycle share one handoff: reload or fall back to idle
        if (frame_end) begin
            ready = 1'b1;
            if (in_valid_i) begin
                state_d      = ST_SHIFT;
                word_d       = in_data_i;
                sel_d        = '0;
                ser_bit_d    = in_data_i[0];
                ser_valid_d  = 1'b1;
                frame_last_d = 1'b0;
            end else begin
                state_d      = ST_IDLE;
                sel_d        = '0;
                ser_bit_d    = IDLE_BIT;
                ser_valid_d  = 1'b0;
                frame_last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            sel_q        <= '0;
            ser_bit_q    <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            sel_q        <= sel_d;
            ser_bit_q    <= ser_bit_d;
            ser_valid_q  <= ser_valid_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign in_ready_o   = ready;
    assign sel_o        = sel_q;
    assign ser_bit_o    = ser_bit_q;
    assign ser_valid_o  = ser_valid_q;
    assign frame_last_o = frame_last_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux8_frame_serializer.sv
// Directed bench for mux8_frame_serializer: reset, single frame, back-to-back,
// held valid, async abort, and (with SERIALIZER_PARITY_EN) the parity trailer.
module tb_mux8_frame_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       ser_bit;
    logic       ser_valid;
    logic       frame_last;
    logic       busy;

    int errors = 0;
    int checks = 0;

    mux8_frame_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .sel_o        (sel),
        .ser_bit_o    (ser_bit),
        .ser_valid_o  (ser_valid),
        .frame_last_o (frame_last),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(ser_valid), 32'd0);
        chk({tag, " busy"},  32'(busy),      32'd0);
        chk({tag, " sel"},   32'(sel),       32'd0);
        chk({tag, " bit"},   32'(ser_bit),   32'd0);
        chk({tag, " last"},  32'(frame_last), 32'd0);
        chk({tag, " ready"}, 32'(in_ready),  32'd1);
    endtask

    // Word a, optionally followed by b offered from bit offer_at (0 = right after accept).
    task automatic run_frames(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int offer_at, input int nbits);
        logic [7:0] w;
        int k;
        in_data  = a;
        in_valid = 1'b1;
        tick();
        if (offer_at == 0) in_data = b;
        else               in_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (offer_at > 0 && i == offer_at) begin
                in_data  = b;
                in_valid = 1'b1;
            end
            w = (i < 8) ? a : b;
            k = i % 8;
            chk($sformatf("%s sel %0d", tag, i),   32'(sel),        32'(k));
            chk($sformatf("%s bit %0d", tag, i),   32'(ser_bit),    32'(w[k]));
            chk($sformatf("%s valid %0d", tag, i), 32'(ser_valid),  32'd1);
            chk($sformatf("%s last %0d", tag, i),  32'(frame_last), 32'(k == 7));
            chk($sformatf("%s ready %0d", tag, i), 32'(in_ready),   32'(k == 7));
            chk($sformatf("%s busy %0d", tag, i),  32'(busy),       32'd1);
            if (i == 8) in_valid = 1'b0;
            tick();
        end
        chk_idle({tag, " end"});
    endtask

    task automatic run_parity(input string tag, input logic [7:0] a, input logic p);
        in_data  = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s sel %0d", tag, i),   32'(sel),        32'((i < 8) ? i : 7));
            chk($sformatf("%s bit %0d", tag, i),   32'(ser_bit),    32'((i < 8) ? a[i % 8] : p));
            chk($sformatf("%s valid %0d", tag, i), 32'(ser_valid),  32'd1);
            chk($sformatf("%s last %0d", tag, i),  32'(frame_last), 32'(i == 8));
            chk($sformatf("%s ready %0d", tag, i), 32'(in_ready),   32'(i == 8));
            tick();
        end
        chk_idle({tag, " end"});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) tick();
        chk_idle("reset");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk_idle("post reset");

`ifdef SERIALIZER_PARITY_EN
        run_parity("par d6", 8'b1101_0110, 1'b1);
        run_parity("par 00", 8'h00, 1'b0);
`else
        run_frames("single", 8'b1101_0110, 8'h00, -1, 8);
        run_frames("b2b", 8'hA5, 8'h3C, 0, 16);
        run_frames("held", 8'h00, 8'hFF, 3, 16);

        // Abort mid-frame: reset lands between edges and must act at once
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("abort pre sel", 32'(sel),     32'd4);
        chk("abort pre bit", 32'(ser_bit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("abort");
        rst_n    = 1'b1;
        in_data  = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("after abort sel",   32'(sel),       32'd0);
        chk("after abort bit",   32'(ser_bit),   32'd1);
        chk("after abort valid", 32'(ser_valid), 32'd1);
        tick();
        chk("after abort bit1",  32'(ser_bit),   32'd0);
        chk("after abort sel1",  32'(sel),       32'd1);
        repeat (7) tick();
        chk_idle("after abort end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
